// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller.
// Holds the controller state encoding and the hard-wired zero register index.
// Imported by the hazard controller top and the load-use compare.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    TIMEOUT  = 2'd3
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect_lu.sv
// Load-use hazard compare between the load in EX and the sources of the ID instruction.
// Latency: purely combinational, same-cycle result.
// Backpressure: none; the caller decides how to stall on the result.
module hazard_detect_lu
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_regwrite_i,
  input  logic       ex_memtoreg_i,
  output logic       lu_o
);

  logic rs_match;
  logic rt_match;

  // A load into $zero never produces a value worth waiting for.
  always_comb begin
    rs_match = (ex_rd_i == id_rs_i);
    rt_match = id_uses_rt_i & (ex_rd_i == id_rt_i);
    lu_o     = ex_memtoreg_i & ex_regwrite_i & (ex_rd_i != REG_ZERO) & (rs_match | rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch, slow data memory.
// Latency: controls are a same-cycle decode of state plus inputs; only the state is registered.
// Backpressure: a pending data-memory access freezes the whole pipe until dmem_ready or timeout.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int COUNT_W        = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [4:0]         id_rs,
  input  logic [4:0]         id_rt,
  input  logic               id_uses_rt,
  input  logic [4:0]         ex_rd,
  input  logic               ex_regwrite,
  input  logic               ex_memtoreg,
  input  logic               ex_branch_taken,
  input  logic               mem_access,
  input  logic               dmem_ready,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               idex_en,
  output logic               idex_flush,
  output logic               exmem_en,
  output logic               memwb_bubble,
  output logic [COUNT_W-1:0] stall_count,
  output logic               dmem_timeout
);

  import pipe_ctrl_pkg::*;

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  ctrl_state_t        state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [COUNT_W-1:0] stall_q;
  logic               timeout_q;

  logic lu;
  logic ms;
  logic run_decode;
  logic freeze;
  logic stall_inc;

  hazard_detect_lu u_lu (
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .ex_rd_i       (ex_rd),
    .ex_regwrite_i (ex_regwrite),
    .ex_memtoreg_i (ex_memtoreg),
    .lu_o          (lu)
  );

  // Next state, wait counter and the control decode for the current cycle.
  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    ms           = mem_access & ~dmem_ready;
    run_decode   = 1'b0;
    freeze       = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;

    case (state_q)
      INIT: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        idex_en      = 1'b0;
        exmem_en     = 1'b0;
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        memwb_bubble = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        if (ms) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else begin
          run_decode = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          // The completing cycle already behaves as a normal RUN cycle.
          run_decode = 1'b1;
          state_d    = RUN;
          wait_d     = '0;
        end else begin
          freeze = 1'b1;
          if (wait_q == WAIT_LAST) begin
            state_d = TIMEOUT;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
      end
      default: begin
        freeze = 1'b1;
      end
    endcase

    if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (run_decode) begin
      // A taken branch squashes the ID instruction, so its load-use stall is moot.
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end

    stall_inc = ((state_q == RUN) || (state_q == MEM_WAIT)) && !pc_en && (stall_q != '1);
  end

  // State, wait counter, saturating stall counter and sticky timeout flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= INIT;
      wait_q    <= '0;
      stall_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_q | (state_d == TIMEOUT);
      if (stall_inc) begin
        stall_q <= stall_q + COUNT_W'(1);
      end
    end
  end

  assign stall_count  = stall_q;
  assign dmem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl (4-bit stall counter, 16-cycle timeout).
// The driver pushes the hand-computed response of every cycle; a monitor pops it at negedge.
// Control vector order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}.
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] C_INIT = 7'b0010101;
  localparam logic [6:0] C_RUN  = 7'b1101010;
  localparam logic [6:0] C_LU   = 7'b0001110;
  localparam logic [6:0] C_BR   = 7'b1111110;
  localparam logic [6:0] C_FRZ  = 7'b0000001;

  typedef struct {
    string      name;
    logic [6:0] ctrl;
    logic [3:0] cnt;
    logic       to;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_uses_rt = 1'b0;
  logic [4:0] ex_rd = '0;
  logic       ex_regwrite = 1'b0;
  logic       ex_memtoreg = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       mem_access = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble;
  logic [3:0] stall_count;
  logic       dmem_timeout;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(16), .COUNT_W(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_rd           (ex_rd),
    .ex_regwrite     (ex_regwrite),
    .ex_memtoreg     (ex_memtoreg),
    .ex_branch_taken (ex_branch_taken),
    .mem_access      (mem_access),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_en         (idex_en),
    .idex_flush      (idex_flush),
    .exmem_en        (exmem_en),
    .memwb_bubble    (memwb_bubble),
    .stall_count     (stall_count),
    .dmem_timeout    (dmem_timeout)
  );

  always #5 clock = ~clock;

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e   = sb.pop_front();
      act = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble};
      n_cmp++;
      if (act !== e.ctrl || stall_count !== e.cnt || dmem_timeout !== e.to) begin
        n_bad++;
        $display("FAIL %s: got ctrl=%b cnt=%0d to=%b, need ctrl=%b cnt=%0d to=%b",
                 e.name, act, stall_count, dmem_timeout, e.ctrl, e.cnt, e.to);
      end
    end
  end

  task automatic push(input string nm, input logic [6:0] c, input int cnt, input logic to);
    exp_t e;
    e.name = nm;
    e.ctrl = c;
    e.cnt  = 4'(cnt);
    e.to   = to;
    sb.push_back(e);
  endtask

  // One cycle: ID sources {rs, rt, uses_rt}, EX {rd, regwrite, memtoreg, branch}, MEM {access, ready}.
  task automatic step(input string nm,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic [4:0] rd, input logic rw, input logic mtr, input logic br,
                      input logic ma, input logic rdy,
                      input logic [6:0] c, input int cnt, input logic to);
    @(posedge clock);
    #1;
    id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_rd = rd; ex_regwrite = rw; ex_memtoreg = mtr; ex_branch_taken = br;
    mem_access = ma; dmem_ready = rdy;
    push(nm, c, cnt, to);
  endtask

  task automatic idle(input string nm, input int cnt);
    step(nm, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, cnt, 1'b0);
  endtask

  // Reset low for three cycles, release, one INIT cycle, then first RUN cycle.
  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      reset = 1'b0;
      mem_access = 1'b0; dmem_ready = 1'b0; ex_branch_taken = 1'b0;
      ex_memtoreg = 1'b0; ex_regwrite = 1'b0;
      push("reset_low", C_INIT, 0, 1'b0);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    push("init_cycle", C_INIT, 0, 1'b0);
    idle("first_run", 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, need finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();

    // Load-use and its non-hazard variants.
    step("lu_rs",        5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,  0, 1'b0);
    idle("after_lu_rs", 1);
    step("lu_rt",        5'd3, 5'd8, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,  1, 1'b0);
    idle("after_lu_rt", 2);
    step("rt_unused",    5'd3, 5'd8, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2, 1'b0);
    step("rd_zero",      5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2, 1'b0);
    step("no_regwrite",  5'd8, 5'd0, 1'b0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_RUN, 2, 1'b0);
    step("not_load",     5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN, 2, 1'b0);

    // Taken branch beats load-use.
    step("branch_over_lu", 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, C_BR, 2, 1'b0);
    idle("after_branch", 2);

    // Three-cycle memory stall, ready on the fourth.
    step("mem_wait_1",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 2, 1'b0);
    step("mem_wait_2",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 3, 1'b0);
    step("mem_wait_3",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 4, 1'b0);
    step("mem_ready",    5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN, 5, 1'b0);
    step("mem_fast_1",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN, 5, 1'b0);
    step("mem_fast_2",   5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RUN, 5, 1'b0);

    // Memory stall outranks a branch; the completing cycle decodes load-use / branch.
    step("ms_over_branch", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_FRZ, 5, 1'b0);
    step("ready_with_lu",  5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, C_LU,  6, 1'b0);
    idle("after_ready_lu", 7);
    step("ms_again",       5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 7, 1'b0);
    step("ready_with_br",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, C_BR,  8, 1'b0);
    idle("after_ready_br", 8);

    // Timeout after sixteen frozen cycles, sticky until reset.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step("timeout_wait", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
           C_FRZ, (i > 15) ? 15 : i, 1'b0);
    end
    step("timeout_entry", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, 15, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("timeout_sticky", 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, C_FRZ, 15, 1'b1);
    end
    idle("timeout_idle_in", 15);
    sb[sb.size()-1].ctrl = C_FRZ;
    sb[sb.size()-1].to   = 1'b1;

    // Reset during the wait clears everything, no timeout afterwards.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step("abort_wait", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_FRZ, i, 1'b0);
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      idle("post_abort", 0);
    end

    // Saturation of the 4-bit stall counter under back-to-back load-use.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step("sat_lu", 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
           C_LU, (i > 15) ? 15 : i, 1'b0);
    end
    idle("sat_hold", 15);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(posedge clock);
    end
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, need 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS32 pipeline.
- Drives the enable, flush and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Handles three hazards:
  - load-use;
  - taken branch resolved in EX;
  - multi-cycle data-memory access, with a ready handshake and a timeout.
- Keeps a saturating stall-cycle counter for performance checks.

Parameters:
TIMEOUT_CYCLES, 16, max consecutive MEM_WAIT cycles before a fatal timeout (>=2)
COUNT_W, 16, width of stall_count

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_rd  in  5  destination register of the instruction in EX
ex_regwrite  in  1  EX instruction writes the register file
ex_memtoreg  in  1  EX instruction is a load
ex_branch_taken  in  1  branch in EX resolved taken
mem_access  in  1  MEM stage holds a load or store
dmem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID clear to NOP
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX clear to bubble
exmem_en  out  1  EX/MEM load enable
memwb_bubble  out  1  force MEM/WB memtoreg and regwrite to 0 this cycle
stall_count  out  COUNT_W  saturating count of stall cycles
dmem_timeout  out  1  sticky fatal flag

Behaviour:
- State register updates on the rising edge of clock. Control outputs are combinational decode of state plus current inputs; no added latency.
- States: INIT, RUN, MEM_WAIT, TIMEOUT.
- Reset low (asynchronous):
  - state is INIT; stall_count is 0; dmem_timeout is 0; wait counter is 0.
  - outputs follow the INIT decode.
- INIT decode: pc_en=0, ifid_en=0, idex_en=0, exmem_en=0, ifid_flush=1, idex_flush=1, memwb_bubble=1. Lasts exactly one clock after reset release, then RUN.
- Load-use condition (LU): ex_memtoreg & ex_regwrite & (ex_rd!=0) & ((ex_rd==id_rs) | (id_uses_rt & (ex_rd==id_rt))).
- Memory stall condition (MS): mem_access & ~dmem_ready.
- Default decode in RUN: all enables 1, all flushes 0, memwb_bubble=0.
- RUN priority is MS > branch > LU:
  1. MS: pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1; next state MEM_WAIT; wait counter loads 1.
  2. Else ex_branch_taken: pc_en=1, ifid_flush=1, idex_flush=1. A taken branch overrides LU, because the ID instruction is wrong-path.
  3. Else LU: pc_en=0, ifid_en=0, idex_flush=1; EX/MEM and MEM/WB advance normally. Exactly one bubble per load-use pair.
- MEM_WAIT:
  - dmem_ready=1: leave for RUN; the same cycle is decoded as RUN (branch/LU evaluated, MS false).
  - Else: freeze decode as in MS; wait counter increments.
  - Wait counter == TIMEOUT_CYCLES-1 with dmem_ready=0: next state TIMEOUT.
- TIMEOUT:
  - Freeze decode with memwb_bubble=1; dmem_timeout=1.
  - Exits only via reset; inputs are ignored.
- stall_count increments by 1 on every RUN or MEM_WAIT cycle with pc_en=0.
  - Saturates at all-ones; never wraps.
  - Not incremented in INIT or TIMEOUT.
- Reset asserted mid-MEM_WAIT: immediate INIT decode; counters cleared; no timeout flagged.
- mem_access held with dmem_ready=1 continuously: zero stall cycles.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding constants (INIT=2'd0, RUN=2'd1, MEM_WAIT=2'd2, TIMEOUT=2'd3);
  - REG_ZERO=5'd0.
- Natural sub-module: hazard_detect_lu, the combinational LU compare, reusable by the forwarding unit.
- FSM, wait counter and stall counter stay in the top module.

Test Plan:
- Reset low 3 cycles, then release -> during reset and the first cycle after: pc_en=0, ifid_flush=1, memwb_bubble=1, stall_count=0; the second cycle is RUN with all enables 1.
- Load-use: ex_memtoreg=1, ex_regwrite=1, ex_rd=5'd8, id_rs=5'd8 -> exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_count=1. Repeat with ex_rd=0 -> no stall.
- Taken branch coincident with LU -> pc_en=1, ifid_flush=1, idex_flush=1, no stall; stall_count unchanged.
- mem_access=1 with dmem_ready low 3 cycles, high on the 4th -> 3 frozen cycles with memwb_bubble=1, normal on the 4th; stall_count +3.
- TIMEOUT_CYCLES=16, dmem_ready never asserted -> TIMEOUT entered after 16 frozen cycles; dmem_timeout=1 and holds until reset. Reset mid-wait (cycle 10) -> dmem_timeout stays 0.
- COUNT_W=4, 20 LU stalls -> stall_count saturates at 4'hF.
